// File: rtl/apb5_requester.sv
// apb5_requester: APB5 requester (master side of the APB5 interface).
// Converts a valid/ready command stream into single APB5 transfers
// (SETUP then ACCESS), waits for pready and returns read data and status
// on a valid/ready response stream.
//
// Ports:
//   pclk, preset                  clock, synchronous active-high reset
//   cmd_*                         command stream (valid/ready), one transfer each
//   rsp_*                         response stream (valid/ready)
//   paddr..pwuser, pwakeup        APB5 requester outputs
//   pready..pbuser                APB5 completer responses
//
// Optional feature: define APB5_REQUESTER_TIMEOUT_EN to enable the ACCESS
// watchdog. It aborts a transfer after TIMEOUT_CYCLES wait cycles and reports
// rsp_err=1 with rsp_timeout=1. Without the macro, ACCESS waits indefinitely
// and rsp_timeout is tied low.
module apb5_requester #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,   // 8, 16 or 32
    parameter int USER_REQ_WIDTH  = 1,
    parameter int USER_DATA_WIDTH = 1,
    parameter int USER_RESP_WIDTH = 1,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                       pclk,
    input  logic                       preset,
    // command stream
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr,
    input  logic                       cmd_write,
    input  logic [DATA_WIDTH-1:0]      cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]    cmd_strb,
    input  logic [2:0]                 cmd_prot,
    input  logic                       cmd_nse,
    input  logic [USER_REQ_WIDTH-1:0]  cmd_auser,
    input  logic [USER_DATA_WIDTH-1:0] cmd_wuser,
    // response stream
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic [USER_DATA_WIDTH-1:0] rsp_ruser,
    output logic [USER_RESP_WIDTH-1:0] rsp_buser,
    output logic                       rsp_timeout,
    // APB5 requester outputs
    output logic [ADDR_WIDTH-1:0]      paddr,
    output logic [2:0]                 pprot,
    output logic                       pnse,
    output logic                       pselx,
    output logic                       penable,
    output logic                       pwrite,
    output logic [DATA_WIDTH-1:0]      pwdata,
    output logic [DATA_WIDTH/8-1:0]    pstrb,
    output logic                       pwakeup,
    output logic [USER_REQ_WIDTH-1:0]  pauser,
    output logic [USER_DATA_WIDTH-1:0] pwuser,
    // APB5 completer responses
    input  logic                       pready,
    input  logic [DATA_WIDTH-1:0]      prdata,
    input  logic                       pslverr,
    input  logic [USER_DATA_WIDTH-1:0] pruser,
    input  logic [USER_RESP_WIDTH-1:0] pbuser
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      paddr_q, paddr_d;
    logic [2:0]                 pprot_q, pprot_d;
    logic                       pnse_q, pnse_d;
    logic                       pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
    logic [DATA_WIDTH/8-1:0]    pstrb_q, pstrb_d;
    logic [USER_REQ_WIDTH-1:0]  pauser_q, pauser_d;
    logic [USER_DATA_WIDTH-1:0] pwuser_q, pwuser_d;
    logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic                       rsp_err_q, rsp_err_d;
    logic [USER_DATA_WIDTH-1:0] rsp_ruser_q, rsp_ruser_d;
    logic [USER_RESP_WIDTH-1:0] rsp_buser_q, rsp_buser_d;
    logic                       accept;
    logic                       tmo_hit;

`ifdef APB5_REQUESTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;

    // Limit is hit in the ACCESS cycle whose pready=0 would bring the count
    // to TIMEOUT_CYCLES; a pready in that same cycle still completes normally.
    assign tmo_hit     = (state_q == S_ACCESS) && !pready &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_timeout = rsp_timeout_q;
`else
    assign tmo_hit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign accept = cmd_valid && cmd_ready;

    // State and datapath registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= S_IDLE;
            paddr_q     <= '0;
            pprot_q     <= '0;
            pnse_q      <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pauser_q    <= '0;
            pwuser_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_ruser_q <= '0;
            rsp_buser_q <= '0;
`ifdef APB5_REQUESTER_TIMEOUT_EN
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pprot_q     <= pprot_d;
            pnse_q      <= pnse_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pauser_q    <= pauser_d;
            pwuser_q    <= pwuser_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_ruser_q <= rsp_ruser_d;
            rsp_buser_q <= rsp_buser_d;
`ifdef APB5_REQUESTER_TIMEOUT_EN
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    // Next state and next datapath values
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pprot_d     = pprot_q;
        pnse_d      = pnse_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pauser_d    = pauser_q;
        pwuser_d    = pwuser_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_ruser_d = rsp_ruser_q;
        rsp_buser_d = rsp_buser_q;
`ifdef APB5_REQUESTER_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    paddr_d  = cmd_addr;
                    pprot_d  = cmd_prot;
                    pnse_d   = cmd_nse;
                    pwrite_d = cmd_write;
                    pauser_d = cmd_auser;
                    pwuser_d = cmd_wuser;
                    // Reads carry no strobes and leave pwdata untouched to
                    // avoid needless toggling on the bus.
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    if (cmd_write) begin
                        pwdata_d = cmd_wdata;
                    end
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
`ifdef APB5_REQUESTER_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    rsp_ruser_d = pruser;
                    rsp_buser_d = pbuser;
`ifdef APB5_REQUESTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d     = S_RESP;
                end else if (tmo_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_ruser_d = '0;
                    rsp_buser_d = '0;
`ifdef APB5_REQUESTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b1;
`endif
                    state_d     = S_RESP;
                end else begin
`ifdef APB5_REQUESTER_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and registers
    always_comb begin
        cmd_ready = (state_q == S_IDLE) && !preset;
        pselx     = (state_q == S_SETUP) || (state_q == S_ACCESS);
        penable   = (state_q == S_ACCESS);
        rsp_valid = (state_q == S_RESP);
        pwakeup   = cmd_valid || (state_q != S_IDLE);
        paddr     = paddr_q;
        pprot     = pprot_q;
        pnse      = pnse_q;
        pwrite    = pwrite_q;
        pwdata    = pwdata_q;
        pstrb     = pstrb_q;
        pauser    = pauser_q;
        pwuser    = pwuser_q;
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
        rsp_ruser = rsp_ruser_q;
        rsp_buser = rsp_buser_q;
    end

endmodule

// File: tb/tb_apb5_requester.sv
module tb_apb5_requester;

    localparam int TMO = 4;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_nse;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        cmd_auser, cmd_wuser;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        rsp_ruser, rsp_buser;
    logic [31:0] paddr, pwdata, prdata;
    logic [2:0]  pprot;
    logic        pnse, pselx, penable, pwrite, pwakeup, pauser, pwuser;
    logic [3:0]  pstrb;
    logic        pready, pslverr, pruser, pbuser;

    always #5 pclk = ~pclk;

    apb5_requester #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_REQ_WIDTH(1),
        .USER_DATA_WIDTH(1), .USER_RESP_WIDTH(1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot), .cmd_nse(cmd_nse), .cmd_auser(cmd_auser),
        .cmd_wuser(cmd_wuser),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_ruser(rsp_ruser), .rsp_buser(rsp_buser),
        .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pprot(pprot), .pnse(pnse), .pselx(pselx),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pwakeup(pwakeup), .pauser(pauser), .pwuser(pwuser),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .pruser(pruser), .pbuser(pbuser)
    );

    // One transfer: command, completer behaviour and the response it must yield.
    // waits < 0 means the completer never raises pready.
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        nse, auser, wuser;
        int          waits;
        logic [31:0] prdata;
        logic        slverr, ruser, buser;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err, exp_ruser, exp_buser, exp_tmo;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err, ruser, buser, tmo;
    } rsp_t;

    vec_t        vecs[$];
    rsp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] strb, input logic [2:0] prot, input logic nse,
                                input logic au, input logic wu, input int waits,
                                input logic [31:0] prd, input logic se, input logic ru,
                                input logic bu, input int hold, input logic [31:0] e_rd,
                                input logic e_err, input logic e_ru, input logic e_bu,
                                input logic e_tmo);
        vec_t v;
        v.write = wr; v.addr = addr; v.wdata = wd; v.strb = strb; v.prot = prot;
        v.nse = nse; v.auser = au; v.wuser = wu; v.waits = waits; v.prdata = prd;
        v.slverr = se; v.ruser = ru; v.buser = bu; v.hold = hold;
        v.exp_rdata = e_rd; v.exp_err = e_err; v.exp_ruser = e_ru;
        v.exp_buser = e_bu; v.exp_tmo = e_tmo;
        vecs.push_back(v);
    endfunction

    // Runs one transfer in lockstep with the DUT; every step starts at a negedge.
    task automatic do_xfer(input vec_t v);
        rsp_t        e, got;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wd;
        int          n_acc;
        exp_strb = v.write ? v.strb : 4'h0;
        exp_wd   = v.write ? v.wdata : last_wdata;
        chk("idle_pwakeup", pwakeup, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        cmd_strb = v.strb; cmd_prot = v.prot; cmd_nse = v.nse;
        cmd_auser = v.auser; cmd_wuser = v.wuser;
        #1;
        chk("pwakeup_same_cycle", pwakeup, 1);
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.ruser = v.exp_ruser;
        e.buser = v.exp_buser; e.tmo = v.exp_tmo;
        sb.push_back(e);
        // SETUP cycle: scramble cmd inputs and offer a bogus response to be ignored
        @(negedge pclk);
        cmd_valid = 0; cmd_addr = ~v.addr; cmd_wdata = 32'h0BAD_CAFE; cmd_prot = ~v.prot;
        cmd_nse = ~v.nse; cmd_auser = ~v.auser;
        pready = 1; pslverr = 1; prdata = 32'hFFFF_FFFF; pruser = 1; pbuser = 1;
        chk("setup_pselx", pselx, 1);
        chk("setup_penable", penable, 0);
        chk("setup_paddr", paddr, v.addr);
        chk("setup_pwrite", pwrite, v.write);
        chk("setup_pstrb", pstrb, exp_strb);
        chk("setup_pwdata", pwdata, exp_wd);
        chk("setup_pprot", pprot, v.prot);
        chk("setup_pnse", pnse, v.nse);
        chk("setup_pauser", pauser, v.auser);
        chk("setup_pwuser", pwuser, v.wuser);
        n_acc = (v.waits < 0) ? TMO : v.waits + 1;
        for (int i = 0; i < n_acc; i++) begin
            @(negedge pclk);
            chk("access_pselx", pselx, 1);
            chk("access_penable", penable, 1);
            chk("access_rsp_valid", rsp_valid, 0);
            chk("access_paddr", paddr, v.addr);
            chk("access_pstrb", pstrb, exp_strb);
            chk("access_pprot", pprot, v.prot);
            chk("access_pnse", pnse, v.nse);
            chk("access_pauser", pauser, v.auser);
            pready  = (v.waits >= 0) && (i == v.waits);
            pslverr = v.slverr; prdata = v.prdata; pruser = v.ruser; pbuser = v.buser;
        end
        // RESP: completer now drives junk that must not leak into the response
        @(negedge pclk);
        pready = 0; pslverr = ~v.slverr; prdata = 32'h5555_AAAA;
        pruser = ~v.ruser; pbuser = ~v.buser;
        chk("resp_valid", rsp_valid, 1);
        chk("resp_pselx", pselx, 0);
        chk("resp_penable", penable, 0);
        chk("resp_cmd_ready", cmd_ready, 0);
        chk("resp_pwakeup", pwakeup, 1);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge pclk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("hold_rsp_err", rsp_err, v.exp_err);
        end
        rsp_ready = 1;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got response, want none queued");
        end else begin
            got = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, got.rdata);
            chk("rsp_err", rsp_err, got.err);
            chk("rsp_ruser", rsp_ruser, got.ruser);
            chk("rsp_buser", rsp_buser, got.buser);
            chk("rsp_timeout", rsp_timeout, got.tmo);
        end
        @(negedge pclk);
        rsp_ready = 0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
        chk("post_pwakeup", pwakeup, 0);
        chk("post_paddr_kept", paddr, v.addr);
        chk("post_pprot_kept", pprot, v.prot);
        chk("post_pwdata_kept", pwdata, exp_wd);
        if (v.write) last_wdata = v.wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        preset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        cmd_strb = 0; cmd_prot = 0; cmd_nse = 0; cmd_auser = 0; cmd_wuser = 0;
        rsp_ready = 0; pready = 0; prdata = 0; pslverr = 0; pruser = 0; pbuser = 0;
        last_wdata = 0;

        //   wr addr          wdata         strb prot    nse au wu wt prdata       se ru bu hold exp_rdata    err ru bu tmo
        add(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 0, 1, 0, 32'hFFFF_0000, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0);
        add(0, 32'h0000_0020, 32'h0,         4'hF, 3'b000, 0, 0, 0, 3, 32'h1234_5678, 0, 0, 0, 0, 32'h1234_5678, 0, 0, 0, 0);
        add(0, 32'h0000_0030, 32'h0,         4'h0, 3'b001, 0, 0, 0, 0, 32'hBAD0_0000, 1, 1, 1, 5, 32'hBAD0_0000, 1, 1, 1, 0);
        add(1, 32'h0000_0044, 32'h0000_A5A5, 4'h3, 3'b111, 1, 1, 0, 1, 32'h7777_7777, 1, 1, 0, 1, 32'h0,          1, 1, 0, 0);
        add(0, 32'h0000_0048, 32'h0,         4'h0, 3'b111, 1, 1, 1, 2, 32'hCAFE_F00D, 0, 1, 0, 2, 32'hCAFE_F00D, 0, 1, 0, 0);

        // reset state
        @(negedge pclk);
        @(negedge pclk);
        chk("rst_pselx", pselx, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwakeup", pwakeup, 0);
        preset = 0;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);
        @(negedge pclk);

        foreach (vecs[i]) do_xfer(vecs[i]);

        // reset asserted during the ACCESS cycle of a write
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_0050; cmd_wdata = 32'h1111_2222;
        cmd_strb = 4'hF; cmd_prot = 3'b011;
        @(negedge pclk);
        cmd_valid = 0;
        @(negedge pclk);
        chk("rstx_access_penable", penable, 1);
        preset = 1; pready = 0;
        @(negedge pclk);
        chk("rstx_pselx", pselx, 0);
        chk("rstx_penable", penable, 0);
        chk("rstx_rsp_valid", rsp_valid, 0);
        chk("rstx_paddr", paddr, 0);
        chk("rstx_pwdata", pwdata, 0);
        chk("rstx_pstrb", pstrb, 0);
        chk("rstx_cmd_ready", cmd_ready, 0);
        preset = 0;
        #1;
        chk("rstx_rel_cmd_ready", cmd_ready, 1);
        @(negedge pclk);
        chk("rstx_no_rsp", rsp_valid, 0);
        chk("rstx_scoreboard_empty", sb.size(), 0);
        last_wdata = 0;
        vecs.delete();
        add(0, 32'h0000_0060, 32'h0, 4'h0, 3'b000, 0, 0, 0, 1, 32'h0BEE_F00D, 0, 0, 1, 0, 32'h0BEE_F00D, 0, 0, 1, 0);
`ifdef APB5_REQUESTER_TIMEOUT_EN
        // never ready: aborted after TMO ACCESS cycles; pready on the TMO-th cycle wins
        add(0, 32'h0000_0070, 32'h0, 4'h0, 3'b000, 0, 0, 0, -1,      32'hDEAD_0001, 0, 1, 1, 0, 32'h0,          1, 0, 0, 1);
        add(0, 32'h0000_0074, 32'h0, 4'h0, 3'b000, 0, 0, 0, TMO - 1, 32'h0F0F_0F0F, 0, 0, 0, 0, 32'h0F0F_0F0F, 0, 0, 0, 0);
`endif
        foreach (vecs[i]) do_xfer(vecs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
